// File: rtl/log_lane_ctrl_pkg.sv
// Shared constants, the log x-position type and the wrap-aware step helper.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package log_lane_ctrl_pkg;

    localparam int LOG_W    = 48;   // sprite width, pixels
    localparam int LOG_H    = 24;   // sprite height, pixels
    localparam int SCREEN_W = 640;  // visible raster width

    // Palette index 0 is never drawn.
    localparam logic [7:0] TRANSPARENT_IDX = 8'd0;

    // Left edge of a log; negative while it slides in/out on the left.
    typedef logic signed [10:0] xpos_t;

    // A log wraps once it is fully off one side: at -47 only its last
    // column is visible at x=0, at 639 only its first column at x=639.
    localparam xpos_t X_WRAP_LO = xpos_t'(-(LOG_W - 1));
    localparam xpos_t X_WRAP_HI = xpos_t'(SCREEN_W - 1);

    // One pixel of movement with wrap-around.
    function automatic xpos_t next_x(input xpos_t x, input logic dir);
        xpos_t r;
        if (dir) begin
            r = (x == X_WRAP_HI) ? X_WRAP_LO : x + 11'sd1;
        end else begin
            r = (x == X_WRAP_LO) ? X_WRAP_HI : x - 11'sd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/log_mover.sv
// Frame-rate prescaler plus per-log horizontal position registers with wrap.
// Latency: positions update on the clock edge that samples the stepping frame_tick.
// Backpressure: none; frame_tick is a free-running pulse and is never held off.
//
// Ports:
//   Clk, Reset        - clock, synchronous active-high reset
//   frame_tick        - one-cycle pulse per video frame
//   enable            - 1 = prescaler counts and logs move, 0 = everything frozen
//   dir               - 0 = left, 1 = right
//   speed             - frame ticks per pixel step, minus one
//   log_x             - left-edge x of every log (registered)
module log_mover
    import log_lane_ctrl_pkg::*;
#(
    parameter int NUM_LOGS = 3,
    parameter int SPACING  = 224
) (
    input  logic                    Clk,
    input  logic                    Reset,
    input  logic                    frame_tick,
    input  logic                    enable,
    input  logic                    dir,
    input  logic [2:0]              speed,
    output xpos_t [NUM_LOGS-1:0]    log_x
);

    logic [2:0]             presc_q, presc_d;
    xpos_t [NUM_LOGS-1:0]   log_x_q, log_x_d;
    logic                   step;

    always_comb begin
        presc_d = presc_q;
        log_x_d = log_x_q;
        step    = 1'b0;

        if (enable && frame_tick) begin
            // ">=" rather than "==": if speed is lowered below the current
            // count, the next tick still steps instead of counting through 7.
            if (presc_q >= speed) begin
                presc_d = '0;
                step    = 1'b1;
            end else begin
                presc_d = presc_q + 3'd1;
            end
        end

        if (step) begin
            for (int i = 0; i < NUM_LOGS; i++) begin
                log_x_d[i] = next_x(log_x_q[i], dir);
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            presc_q <= '0;
            for (int i = 0; i < NUM_LOGS; i++) begin
                log_x_q[i] <= xpos_t'(i * SPACING);
            end
        end else begin
            presc_q <= presc_d;
            log_x_q <= log_x_d;
        end
    end

    assign log_x = log_x_q;

endmodule

// File: rtl/log_lane_ctrl.sv
// Log lane: moves NUM_LOGS logs and resolves raster pixels against one shared sprite ROM.
// Latency: DrawX/DrawY to pix_valid/pix_index is exactly 2 cycles, one pixel per cycle.
// Backpressure: none; the pipeline never stalls.
//
// Ports:
//   Clk, Reset          - clock, synchronous active-high reset (flushes both stages)
//   frame_tick, enable, dir, speed - motion control, see log_mover
//   DrawX, DrawY        - current raster pixel
//   rom_DX, rom_DY      - registered sprite ROM address (stage 1)
//   rom_data            - combinational ROM palette index for rom_DX/rom_DY
//   pix_valid, pix_index - registered lane pixel result (stage 2)
//   log_x               - left-edge x of every log, for the frog-riding logic
module log_lane_ctrl
    import log_lane_ctrl_pkg::*;
#(
    parameter int NUM_LOGS = 3,
    parameter int LANE_Y   = 96,
    parameter int SPACING  = 224
) (
    input  logic                    Clk,
    input  logic                    Reset,
    input  logic                    frame_tick,
    input  logic                    enable,
    input  logic                    dir,
    input  logic [2:0]              speed,
    input  logic [9:0]              DrawX,
    input  logic [9:0]              DrawY,
    output logic [5:0]              rom_DX,
    output logic [5:0]              rom_DY,
    input  logic [7:0]              rom_data,
    output logic                    pix_valid,
    output logic [7:0]              pix_index,
    output xpos_t [NUM_LOGS-1:0]    log_x
);

    // ------------------------------------------------------------------
    // Motion
    // ------------------------------------------------------------------
    log_mover #(
        .NUM_LOGS (NUM_LOGS),
        .SPACING  (SPACING)
    ) u_mover (
        .Clk        (Clk),
        .Reset      (Reset),
        .frame_tick (frame_tick),
        .enable     (enable),
        .dir        (dir),
        .speed      (speed),
        .log_x      (log_x)
    );

    // ------------------------------------------------------------------
    // Stage 1: hit test and ROM address
    // Uses the registered log_x, so a step landing in the same cycle as a
    // lookup is seen only by the following pixel.
    // ------------------------------------------------------------------
    logic [5:0] rom_DX_q, rom_DX_d;
    logic [5:0] rom_DY_q, rom_DY_d;
    logic       hit1_q,   hit1_d;

    logic [9:0]  dy;
    logic        in_lane_y;
    logic [11:0] dx;

    always_comb begin
        rom_DX_d  = '0;
        rom_DY_d  = '0;
        hit1_d    = 1'b0;
        dx        = '0;

        dy        = DrawY - 10'(LANE_Y);
        in_lane_y = (DrawY >= 10'(LANE_Y)) && (dy < 10'(LOG_H));

        // Walk from the highest index down so the lowest hitting log is the
        // last writer and therefore wins.
        for (int i = NUM_LOGS - 1; i >= 0; i--) begin
            // 12-bit two's complement difference; DrawX is 0..1023 and
            // log_x is -47..639, so the result never overflows. A negative
            // result (bit 11 set) means the pixel is left of the log.
            dx = {2'b00, DrawX} - {log_x[i][10], log_x[i]};
            if (in_lane_y && !dx[11] && (dx < 12'(LOG_W))) begin
                hit1_d   = 1'b1;
                rom_DX_d = dx[5:0];
                rom_DY_d = dy[5:0];
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: ROM result and transparency
    // ------------------------------------------------------------------
    logic       pix_valid_q, pix_valid_d;
    logic [7:0] pix_index_q, pix_index_d;

    always_comb begin
        pix_index_d = rom_data;
        pix_valid_d = hit1_q && (rom_data != TRANSPARENT_IDX);
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            rom_DX_q    <= '0;
            rom_DY_q    <= '0;
            hit1_q      <= 1'b0;
            pix_valid_q <= 1'b0;
            pix_index_q <= '0;
        end else begin
            rom_DX_q    <= rom_DX_d;
            rom_DY_q    <= rom_DY_d;
            hit1_q      <= hit1_d;
            pix_valid_q <= pix_valid_d;
            pix_index_q <= pix_index_d;
        end
    end

    assign rom_DX    = rom_DX_q;
    assign rom_DY    = rom_DY_q;
    assign pix_valid = pix_valid_q;
    assign pix_index = pix_index_q;

endmodule

// File: tb/tb_log_lane_ctrl.sv
// Bench for log_lane_ctrl: two instances share all inputs; dut_a uses the
// default spacing, dut_b uses spacing 20 so its logs overlap.
module tb_log_lane_ctrl;

    logic       Clk = 1'b0;
    logic       Reset;
    logic       frame_tick;
    logic       enable;
    logic       dir;
    logic [2:0] speed;
    logic [9:0] DrawX;
    logic [9:0] DrawY;

    logic [5:0]        dxa, dya, dxb, dyb;
    logic [7:0]        rda, rdb, pia, pib;
    logic              pva, pvb;
    logic [2:0][10:0]  lxa, lxb;

    always #5 Clk = ~Clk;

    // Sprite ROM model: zero at (0,0) and wherever x == y*4 (low bits).
    function automatic logic [7:0] rom_fn(input logic [5:0] x, input logic [5:0] y);
        return {2'b00, x ^ {y[3:0], 2'b00}};
    endfunction

    assign rda = rom_fn(dxa, dya);
    assign rdb = rom_fn(dxb, dyb);

    log_lane_ctrl #(.NUM_LOGS(3), .LANE_Y(96), .SPACING(224)) dut_a (
        .Clk(Clk), .Reset(Reset), .frame_tick(frame_tick), .enable(enable),
        .dir(dir), .speed(speed), .DrawX(DrawX), .DrawY(DrawY),
        .rom_DX(dxa), .rom_DY(dya), .rom_data(rda),
        .pix_valid(pva), .pix_index(pia), .log_x(lxa)
    );

    log_lane_ctrl #(.NUM_LOGS(3), .LANE_Y(96), .SPACING(20)) dut_b (
        .Clk(Clk), .Reset(Reset), .frame_tick(frame_tick), .enable(enable),
        .dir(dir), .speed(speed), .DrawX(DrawX), .DrawY(DrawY),
        .rom_DX(dxb), .rom_DY(dyb), .rom_data(rdb),
        .pix_valid(pvb), .pix_index(pib), .log_x(lxb)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int lid    = 0;

    always @(posedge Clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int id, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s #%0d: got %0d expected %0d", nm, id, act, exp);
        end
    endtask

    typedef struct {
        int         due;
        int         id;
        bit         sel;
        logic [5:0] dx;
        logic [5:0] dy;
        logic       vld;
        logic [7:0] idx;
    } exp_t;

    exp_t s1_q[$];
    exp_t s2_q[$];

    task automatic nc();
        @(posedge Clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) begin
            frame_tick = 1'b1;
            nc();
            frame_tick = 1'b0;
            nc();
        end
    endtask

    // Present one pixel; expectations are hand-computed by the caller.
    // flush=1 means a reset will hit while this pixel is in stage 2.
    task automatic lookup(input bit sel, input int x, input int y, input bit hit,
                          input int edx, input int edy, input bit flush);
        exp_t e;
        DrawX = 10'(x);
        DrawY = 10'(y);
        lid++;
        e.id  = lid;
        e.sel = sel;
        e.dx  = hit ? 6'(edx) : 6'd0;
        e.dy  = hit ? 6'(edy) : 6'd0;
        e.due = cyc + 1;
        e.vld = 1'b0;
        e.idx = 8'd0;
        s1_q.push_back(e);
        e.due = cyc + 2;
        e.idx = flush ? 8'd0 : rom_fn(e.dx, e.dy);
        e.vld = !flush && hit && (rom_fn(e.dx, e.dy) != 8'd0);
        s2_q.push_back(e);
        nc();
    endtask

    task automatic mon();
        exp_t e;
        if (s1_q.size() > 0 && s1_q[0].due <= cyc) begin
            e = s1_q.pop_front();
            chk("s1_timing", e.id, cyc, e.due);
            chk("rom_DX", e.id, int'(e.sel ? dxb : dxa), int'(e.dx));
            chk("rom_DY", e.id, int'(e.sel ? dyb : dya), int'(e.dy));
        end
        if (s2_q.size() > 0 && s2_q[0].due <= cyc) begin
            e = s2_q.pop_front();
            chk("s2_timing", e.id, cyc, e.due);
            chk("pix_valid", e.id, int'(e.sel ? pvb : pva), int'(e.vld));
            chk("pix_index", e.id, int'(e.sel ? pib : pia), int'(e.idx));
        end
    endtask

    initial begin
        forever begin
            @(negedge Clk);
            mon();
        end
    end

    task automatic chk_a(input string nm, input int x0, input int x1, input int x2);
        chk({nm, "_a0"}, 0, int'($signed(lxa[0])), x0);
        chk({nm, "_a1"}, 0, int'($signed(lxa[1])), x1);
        chk({nm, "_a2"}, 0, int'($signed(lxa[2])), x2);
    endtask

    task automatic chk_b(input string nm, input int x0, input int x1, input int x2);
        chk({nm, "_b0"}, 0, int'($signed(lxb[0])), x0);
        chk({nm, "_b1"}, 0, int'($signed(lxb[1])), x1);
        chk({nm, "_b2"}, 0, int'($signed(lxb[2])), x2);
    endtask

    initial begin
        // Reset held with enable and frame_tick active: reset must dominate.
        Reset = 1'b1; frame_tick = 1'b1; enable = 1'b1; dir = 1'b1;
        speed = 3'd0; DrawX = 10'd0; DrawY = 10'd96;
        repeat (3) nc();
        chk_a("rst", 0, 224, 448);
        chk_b("rst", 0, 20, 40);
        chk("rst_pix_valid", 0, int'(pva), 0);
        chk("rst_pix_index", 0, int'(pia), 0);
        chk("rst_rom_DX", 0, int'(dxa), 0);
        chk("rst_rom_DY", 0, int'(dya), 0);

        Reset = 1'b0; frame_tick = 1'b0; enable = 1'b0;

        // Log0 column 0, row 0 is transparent.
        lookup(0, 0, 96, 1, 0, 0, 0);
        nc(); nc();

        // Prescaler: speed 2 -> one step per 3 ticks.
        enable = 1'b1; dir = 1'b1; speed = 3'd2;
        ticks(6);
        chk_a("spd2", 2, 226, 450);
        chk_b("spd2", 2, 22, 42);

        // Count to 3 at speed 7, then drop speed below the count.
        speed = 3'd7;
        ticks(3);
        chk_a("spd7", 2, 226, 450);
        speed = 3'd0;
        ticks(1);
        chk_a("spd_drop", 3, 227, 451);
        ticks(7);
        chk_a("pos10", 10, 234, 458);
        chk_b("pos10", 10, 30, 50);

        // Back-to-back pixels, one per cycle.
        lookup(1, 40, 105, 1, 30, 9, 0);   // overlap on dut_b, log0 wins
        lookup(0, 40, 105, 1, 30, 9, 0);
        lookup(0, 40, 95, 0, 0, 0, 0);     // row above lane
        lookup(0, 40, 120, 0, 0, 0, 0);    // row below lane
        lookup(0, 57, 119, 1, 47, 23, 0);  // bottom-right corner of log0
        lookup(0, 58, 110, 0, 0, 0, 0);    // one past right edge
        lookup(0, 14, 97, 1, 4, 1, 0);     // hit but transparent texel
        nc(); nc();

        // Frozen: ticks ignored.
        enable = 1'b0;
        ticks(10);
        chk_a("frozen", 10, 234, 458);

        // Move left to the wrap point and across it.
        enable = 1'b1; dir = 1'b0; speed = 3'd0;
        ticks(57);
        chk_a("left57", -47, 177, 401);
        ticks(1);
        chk_a("wrap_left", 639, 176, 400);
        dir = 1'b1;
        ticks(1);
        chk_a("wrap_right", -47, 177, 401);

        // Partially off-screen log0: only its last column is visible.
        lookup(0, 0, 100, 1, 47, 4, 0);
        lookup(0, 1, 100, 0, 0, 0, 0);
        nc(); nc();

        // Step in the same cycle as a lookup: pre-step position is used.
        frame_tick = 1'b1;
        lookup(0, 0, 100, 1, 47, 4, 0);
        frame_tick = 1'b0;
        nc(); nc();
        chk_a("step_then", -46, 178, 402);

        // Reset while a visible pixel is in flight.
        lookup(0, 0, 100, 1, 46, 4, 1);
        Reset = 1'b1; frame_tick = 1'b1;
        nc();
        chk_a("midrst", 0, 224, 448);
        chk_b("midrst", 0, 20, 40);
        Reset = 1'b0; frame_tick = 1'b0;
        repeat (3) nc();

        chk("sb_drained", 0, s1_q.size() + s2_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
